// File: rtl/axi_ram_slave_pkg.sv
// Shared definitions for the AXI3 RAM slave.
//   state_e      : top-level transaction FSM encoding (IDLE/RD/WR/WRESP)
//   RESP_OKAY    : normal completion response
//   RESP_SLVERR  : write burst whose wlast disagreed with the beat count
//   BEAT_BYTES   : bytes per beat; every burst is INCR with this stride
package axi_ram_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_WRESP = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int BEAT_BYTES = 4;

endpackage

// File: rtl/axi_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables.
//   clk   : clock, rising edge
//   re    : read enable; rdata updates only when re is high, so the last
//           word read stays on rdata for as long as needed
//   we    : byte write enables (bit n writes wdata[8n+7:8n])
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (not reset)
module axi_ram_array #(
    parameter int ADDR_WIDTH = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[addr];
        end
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave memory: serves INCR bursts from a word RAM, one transaction
// at a time. Writes win over reads when both addresses arrive together.
//   aclk, aresetn        : clock (rising edge), async active-low reset
//   ar* / r*             : read address and read data channels
//   aw* / w* / b*        : write address, write data, write response
//   dbg_state            : current FSM state (state_e encoding)
//
// Handshake rule for every channel: a transfer happens on the rising edge
// where valid and ready are both high; the sender holds its payload stable
// while valid is high and ready is low.
//
// Read pipeline: the RAM output register is a one-entry buffer in front of
// the rdata/rvalid output register. ram_vld_q marks it as holding a word
// not yet moved to the output. A new RAM read is issued only when that
// buffer is empty or being emptied this cycle, which gives one beat per
// cycle under rready=1 and loses nothing under backpressure. The first
// word is fetched in the AR handshake cycle so rvalid rises two cycles
// after the handshake.
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,

    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,

    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,

    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,

    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,

    output logic [1:0]  dbg_state
);

    localparam int IDX_LSB = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // FSM and burst bookkeeping. idx/cnt/len are shared by reads and writes
    // since only one transaction is ever in flight.
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;       // next RAM index to access
    logic [7:0]            left_q, left_d;     // read words still to fetch
    logic [7:0]            cnt_q, cnt_d;       // beats completed so far
    logic [7:0]            len_q, len_d;       // burst length minus one
    logic                  ram_vld_q, ram_vld_d;
    logic                  err_q, err_d;

    // Registered outputs
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            rid_q, rid_d;
    logic                  bvalid_q, bvalid_d;
    logic [3:0]            bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;

    // RAM port
    logic                  ram_re;
    logic [3:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_rdata;

    logic                  aw_hs, ar_hs;
    logic                  out_free, move, issue, last_beat;
    logic [ADDR_WIDTH-1:0] ar_idx, aw_idx;

    // Upper address bits and byte offset are intentionally ignored.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{araddr, awaddr};

    assign ar_idx = araddr[IDX_LSB +: ADDR_WIDTH];
    assign aw_idx = awaddr[IDX_LSB +: ADDR_WIDTH];

    // awready_q is only high in IDLE; reads yield to a pending write.
    assign arready = awready_q && !awvalid;
    assign aw_hs   = awvalid && awready_q;
    assign ar_hs   = arvalid && arready;

    axi_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (aclk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ram_vld_d = ram_vld_q;
        err_d     = err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        ram_re    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = idx_q;
        out_free  = !rvalid_q || rready;
        move      = 1'b0;
        issue     = 1'b0;
        last_beat = (cnt_q == len_q);

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    state_d = ST_WR;
                    idx_d   = aw_idx;
                    cnt_d   = 8'd0;
                    len_d   = awlen;
                    bid_d   = awid;
                    err_d   = 1'b0;
                end else if (ar_hs) begin
                    // Fetch the first word right away.
                    state_d   = ST_RD;
                    ram_re    = 1'b1;
                    ram_addr  = ar_idx;
                    idx_d     = ar_idx + IDX_ONE;
                    left_d    = arlen;
                    cnt_d     = 8'd0;
                    len_d     = arlen;
                    rid_d     = arid;
                    ram_vld_d = 1'b1;
                end
            end

            ST_RD: begin
                move  = ram_vld_q && out_free;
                issue = (left_q != 8'd0) && (!ram_vld_q || move);

                if (rvalid_q && rready) begin
                    rvalid_d = 1'b0;
                end
                if (move) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = ram_rdata;
                    rlast_d   = last_beat;
                    cnt_d     = cnt_q + 8'd1;
                    ram_vld_d = 1'b0;
                end
                if (issue) begin
                    ram_re    = 1'b1;
                    ram_addr  = idx_q;
                    idx_d     = idx_q + IDX_ONE;
                    left_d    = left_q - 8'd1;
                    ram_vld_d = 1'b1;
                end
                if (rvalid_q && rready && rlast_q) begin
                    state_d = ST_IDLE;
                    rlast_d = 1'b0;
                end
            end

            ST_WR: begin
                if (wvalid && wready_q) begin
                    ram_we   = wstrb;
                    ram_addr = idx_q;
                    idx_d    = idx_q + IDX_ONE;
                    cnt_d    = cnt_q + 8'd1;
                    if (wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    // The beat count, not wlast, ends the burst.
                    if (last_beat) begin
                        state_d  = ST_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || (wlast != last_beat)) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end

            ST_WRESP: begin
                if (bready) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                    err_d    = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        awready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_WR);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            left_q    <= 8'd0;
            cnt_q     <= 8'd0;
            len_q     <= 8'd0;
            ram_vld_q <= 1'b0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rid_q     <= 4'd0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            left_q    <= left_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            ram_vld_q <= ram_vld_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign rdata     = rdata_q;
    assign rid       = rid_q;
    assign rresp     = RESP_OKAY;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = bresp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: drives AXI write/read bursts, keeps a word
// model of the RAM, and compares read beats against an expected queue.
module tb_axi_ram_slave;
    import axi_ram_slave_pkg::*;

    localparam int AW    = 16;
    localparam int DEPTH = 1 << AW;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model [int];

    axi_ram_slave #(.ADDR_WIDTH(AW), .INIT_FILE("")) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [31:0] base, input logic [3:0] strb, input int bad_beat,
                             input logic [1:0] exp_resp, input bit with_ar);
        int idx, aw_cyc, n;
        logic [31:0] tmp;
        idx = int'(addr[AW+1:2]);
        @(posedge aclk); #1;
        awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
        if (with_ar) begin
            arvalid = 1'b1; araddr = addr; arlen = 8'd0; arid = 4'h0;
        end
        n = 0;
        @(negedge aclk);
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check_eq("aw_accept", awready, 1);
        if (with_ar) check_eq("aw_beats_ar", arready, 0);
        aw_cyc = cyc;
        @(posedge aclk); #1;
        awvalid = 1'b0; arvalid = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1;
            wdata  = base + 32'(b);
            wstrb  = strb;
            wlast  = ((b == int'(len)) != (b == bad_beat));
            n = 0;
            @(negedge aclk);
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            check_eq("w_accept", wready, 1);
            tmp = model.exists((idx + b) % DEPTH) ? model[(idx + b) % DEPTH] : 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) tmp[8*k +: 8] = wdata[8*k +: 8];
            end
            model[(idx + b) % DEPTH] = tmp;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;

        n = 0;
        @(negedge aclk);
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        check_eq("b_valid", bvalid, 1);
        check_eq("bresp", bresp, exp_resp);
        check_eq("bid", bid, id);
        if (len == 8'd0) check_eq("wr_lat", cyc - aw_cyc, 2);
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input bit bp);
        int idx, hs_cyc, first_cyc, beats, n;
        logic [31:0] held_data;
        logic        held_last;
        logic [31:0] exp;
        bit          stalled;
        idx = int'(addr[AW+1:2]);
        for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(model[(idx + i) % DEPTH]);
        end
        @(posedge aclk); #1;
        arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
        rready = !bp;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check_eq("ar_accept", arready, 1);
        hs_cyc = cyc;
        @(posedge aclk); #1;
        arvalid = 1'b0;

        beats = 0; first_cyc = -1; stalled = 1'b0; n = 0;
        held_data = '0; held_last = 1'b0;
        while (beats <= int'(len) && n < 200) begin
            @(negedge aclk);
            n++;
            if (rvalid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check_eq("rd_lat", cyc - hs_cyc, 2);
                end
                if (stalled) begin
                    check_eq("rd_hold_data", rdata, held_data);
                    check_eq("rd_hold_last", rlast, held_last);
                end
                if (rready) begin
                    check_eq("sb_nonempty", exp_q.size() > 0, 1);
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                    check_eq("rdata", rdata, exp);
                    check_eq("rlast", rlast, beats == int'(len));
                    check_eq("rid", rid, id);
                    check_eq("rresp", rresp, RESP_OKAY);
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = rdata;
                    held_last = rlast;
                end
            end
            @(posedge aclk); #1;
            if (bp) rready = ~rready;
        end
        check_eq("rd_beats", beats, int'(len) + 1);
        rready = 1'b0;
        @(negedge aclk);
        check_eq("rd_no_extra", rvalid, 0);
        check_eq("rd_idle_arready", arready, 1);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int beats, n;

        repeat (3) @(negedge aclk);
        check_eq("rst_ar_aw_w_ready", {arready, awready, wready}, 0);
        check_eq("rst_valids", {rvalid, rlast, bvalid}, 0);
        check_eq("rst_ids", {rid, bid}, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_resps", {rresp, bresp}, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check_eq("post_rst_arready", arready, 1);

        // write then read, incl. ignored upper address bits
        axi_write(32'h100, 8'd0, 4'h1, 32'hDEAD_BEEF, 4'hF, -1, RESP_OKAY, 1'b0);
        axi_read (32'h100, 8'd0, 4'h2, 1'b0);
        axi_read (32'hF000_0100, 8'd0, 4'h7, 1'b0);

        // 8-beat burst
        axi_write(32'h0, 8'd7, 4'h3, 32'd0, 4'hF, -1, RESP_OKAY, 1'b0);
        axi_read (32'h0, 8'd7, 4'h4, 1'b0);

        // wrap at the top of RAM
        axi_write(32'h3FFFC, 8'd0, 4'h5, 32'hCAFE_F00D, 4'hF, -1, RESP_OKAY, 1'b0);
        axi_read (32'h3FFFC, 8'd3, 4'h6, 1'b0);

        // backpressure
        axi_read (32'h0, 8'd3, 4'h8, 1'b1);
        axi_read (32'h4, 8'd5, 4'h9, 1'b1);

        // byte strobes, AW wins over a simultaneous AR
        axi_write(32'h200, 8'd0, 4'h9, 32'h1122_3344, 4'hF, -1, RESP_OKAY, 1'b0);
        axi_write(32'h200, 8'd0, 4'hA, 32'hAABB_CCDD, 4'b0101, -1, RESP_OKAY, 1'b1);
        check_eq("strobe_model", model[32'h200 >> 2], 32'h11BB_33DD);
        axi_read (32'h200, 8'd0, 4'hB, 1'b0);

        // wlast mismatch, then clean write
        axi_write(32'h300, 8'd1, 4'hC, 32'h50, 4'hF, 0, RESP_SLVERR, 1'b0);
        axi_write(32'h300, 8'd0, 4'hD, 32'h60, 4'hF, -1, RESP_OKAY, 1'b0);
        axi_read (32'h300, 8'd1, 4'hE, 1'b0);

        // reset during beat 2 of a 4-beat read
        @(posedge aclk); #1;
        arvalid = 1'b1; araddr = 32'h0; arlen = 8'd3; arid = 4'hF; rready = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check_eq("rst_ar_accept", arready, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        beats = 0; n = 0;
        while (n < 50) begin
            @(negedge aclk);
            n++;
            if (rvalid) begin
                if (beats == 2) break;
                beats++;
            end
        end
        check_eq("rst_at_beat2", beats, 2);
        aresetn = 1'b0;
        #1;
        check_eq("midrst_rvalid", rvalid, 0);
        check_eq("midrst_rlast", rlast, 0);
        check_eq("midrst_arready", arready, 0);
        check_eq("midrst_state", dbg_state, ST_IDLE);
        rready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("after_rst_arready", arready, 1);
        check_eq("after_rst_state", dbg_state, ST_IDLE);

        // RAM contents survive reset
        axi_read (32'h100, 8'd0, 4'h3, 1'b0);
        axi_read (32'h0, 8'd2, 4'h4, 1'b0);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
